// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mul/div to the shared multi-cycle unit, freezes the pipeline while it runs,
// and presents the captured result and rstatus code for one advancing cycle.
module multdiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        start_mult,
  output logic        start_div,
  output logic        stall,
  output logic        result_sel,
  output logic [31:0] result,
  output logic [31:0] status_code,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] counter;
  logic op_div;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      counter <= '0;
      op_div <= 1'b0;
      result <= '0;
      status_code <= '0;
    end else begin
      case (state)
        IDLE: if (dx_is_mult | dx_is_div) begin
          state <= START;
          op_div <= dx_is_div & ~dx_is_mult;
        end
        START: begin
          counter <= '0;
          state <= WAIT;
        end
        WAIT: begin
          counter <= counter + 1'b1;
          if (md_ready) begin
            result <= md_result;
            status_code <= md_exception ? (op_div ? 32'd5 : 32'd4) : 32'd0;
            state <= DONE;
          end else if (counter == LAST) begin
            result <= '0;
            status_code <= op_div ? 32'd5 : 32'd4;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Stall in IDLE is combinational so the detecting cycle already holds the op in DX.
  assign stall      = reset & (state == IDLE ? (dx_is_mult | dx_is_div) : state != DONE);
  assign start_mult = state == START && !op_div;
  assign start_div  = state == START && op_div;
  assign result_sel = state == DONE;
  assign busy       = state != IDLE;
endmodule
